// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Round-robin I/D arbiter for the shared four-bank main memory,
//             holding one grant per miss transaction with a post-release drain.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
   parameter int DRAIN_CYC = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic        req_d,
   input  logic        rel_i,
   input  logic        rel_d,
   input  logic [15:0] Addr_i,
   input  logic [15:0] Addr_d,
   input  logic [15:0] DataIn_i,
   input  logic [15:0] DataIn_d,
   input  logic        wr_i,
   input  logic        wr_d,
   input  logic        rd_i,
   input  logic        rd_d,
   input  logic [15:0] DataOut_mem,
   output logic        gnt_i,
   output logic        gnt_d,
   output logic [15:0] Addr_mem,
   output logic [15:0] DataIn_mem,
   output logic        wr_mem,
   output logic        rd_mem,
   output logic [15:0] DataOut_i,
   output logic [15:0] DataOut_d,
   output logic        busy,
   output logic        err
);

   localparam int   CW      = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic c_OWN_I = 1'b0;
   localparam logic c_OWN_D = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_OWN_I = 2'd1,
      S_OWN_D = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_last;
   logic            w_last_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            r_err;
   logic            w_own_i;
   logic            w_own_d;
   logic            w_route_i;
   logic            w_route_d;
   logic            w_violation;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_last  <= c_OWN_I;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_last  <= w_last_nxt;
         r_cnt   <= w_cnt_nxt;
         r_err   <= r_err | w_violation;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            // On a tie the requester that did not own the memory last wins.
            if (req_i && req_d)
               w_state_nxt = (r_last == c_OWN_I) ? S_OWN_D : S_OWN_I;
            else if (req_i)
               w_state_nxt = S_OWN_I;
            else if (req_d)
               w_state_nxt = S_OWN_D;
         end
         S_OWN_I: begin
            if (rel_i) begin
               w_state_nxt = S_DRAIN;
               w_last_nxt  = c_OWN_I;
               w_cnt_nxt   = CW'(DRAIN_CYC - 1);
            end
         end
         S_OWN_D: begin
            if (rel_d) begin
               w_state_nxt = S_DRAIN;
               w_last_nxt  = c_OWN_D;
               w_cnt_nxt   = CW'(DRAIN_CYC - 1);
            end
         end
         S_DRAIN: begin
            if (r_cnt == '0)
               w_state_nxt = S_IDLE;
            else
               w_cnt_nxt = r_cnt - CW'(1);
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_own_i   = (r_state == S_OWN_I);
      w_own_d   = (r_state == S_OWN_D);
      // Read data keeps following the previous owner while the drain runs.
      w_route_i = w_own_i || ((r_state == S_DRAIN) && (r_last == c_OWN_I));
      w_route_d = w_own_d || ((r_state == S_DRAIN) && (r_last == c_OWN_D));

      Addr_mem   = 16'h0000;
      DataIn_mem = 16'h0000;
      wr_mem     = 1'b0;
      rd_mem     = 1'b0;
      if (w_own_i) begin
         Addr_mem   = Addr_i;
         DataIn_mem = DataIn_i;
         wr_mem     = wr_i;
         rd_mem     = rd_i;
      end else if (w_own_d) begin
         Addr_mem   = Addr_d;
         DataIn_mem = DataIn_d;
         wr_mem     = wr_d;
         rd_mem     = rd_d;
      end

      DataOut_i = w_route_i ? DataOut_mem : 16'h0000;
      DataOut_d = w_route_d ? DataOut_mem : 16'h0000;

      w_violation = ((wr_i | rd_i) & ~w_own_i) | ((wr_d | rd_d) & ~w_own_d) |
                    (wr_i & rd_i) | (wr_d & rd_d) |
                    (rel_i & ~w_own_i) | (rel_d & ~w_own_d);
   end

   assign gnt_i = w_own_i;
   assign gnt_d = w_own_d;
   assign busy  = (r_state != S_IDLE);
   assign err   = r_err;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single four-bank main memory between the instruction-cache controller and the data-cache controller. A requester holds one grant for a whole miss transaction: write-back burst plus fill burst. Within that transaction the owner's memory port is muxed onto the memory. After release, a drain window lets in-flight read data reach the old owner before the memory is handed to the other requester. The block sits between the two cache controllers and the four-bank memory, and resolves I/D contention with round-robin priority.

## Interface
Parameters:
- DRAIN_CYC, default 2: idle cycles after release; equals memory read latency (data returns 2 cycles after rd_mem).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req_i / req_d  in  1  level request from I / D controller, held until granted
- rel_i / rel_d  in  1  one-cycle release pulse, asserted on the owner's final memory cycle
- Addr_i / Addr_d  in  16  requester memory address
- DataIn_i / DataIn_d  in  16  requester write data
- wr_i / wr_d, rd_i / rd_d  in  1  requester write / read strobes
- DataOut_mem  in  16  memory read data
- gnt_i / gnt_d  out  1  registered grant
- Addr_mem, DataIn_mem  out  16  to memory
- wr_mem, rd_mem  out  1  to memory
- DataOut_i / DataOut_d  out  16  routed read data
- busy  out  1  state is not IDLE
- err  out  1  sticky protocol-violation flag

## Operation
- States: IDLE, OWN_I, OWN_D, DRAIN. A 2-bit state register and a 1-bit last_owner register, with last_owner reset to I.
- IDLE:
  - Only req_i set → next OWN_I. Only req_d set → next OWN_D.
  - Both set → grant the requester that is not last_owner. After reset, D wins the first tie.
- OWN_x:
  - gnt_x = 1.
  - Addr_mem, DataIn_mem, wr_mem and rd_mem are combinationally equal to requester x's signals.
  - rel_x → next DRAIN. last_owner is set to x, and the drain counter is loaded with DRAIN_CYC-1.
- DRAIN:
  - No grant. Memory strobes are 0.
  - The counter decrements each cycle; at 0 → IDLE.
  - Requests that arrive during DRAIN are held and evaluated in IDLE.
- Data routing:
  - data_owner = x throughout OWN_x and DRAIN following OWN_x.
  - DataOut_x = DataOut_mem when data_owner == x, otherwise 16'h0000.
- Non-owner signals:
  - Strobes (wr/rd) from the non-owner are blocked and never reach memory.
  - rel from the non-owner is ignored.
  - A req drop while granted is ignored; only rel ends ownership.
- err is set (sticky until rst) on any of the following:
  - a non-owner strobe;
  - wr_x and rd_x asserted in the same cycle;
  - rel_x asserted while not owner.
- Outputs when no owner: Addr_mem = 0, DataIn_mem = 0, wr_mem = 0, rd_mem = 0. No x values are ever driven.

## Timing
- Reset values: state IDLE, gnt_i = gnt_d = 0, all memory outputs 0, DataOut_i = DataOut_d = 0, busy = 0, err = 0, last_owner = I, drain counter 0.
- rst in any state, including mid-burst, forces the reset values on the next edge. Any memory access in flight is abandoned.
- Grant latency: req seen high in IDLE at edge N → gnt high from cycle N+1. The owner may strobe memory in that same cycle.
- Release: rel_x at cycle M → gnt_x low at M+1 and DRAIN for cycles M+1 .. M+DRAIN_CYC → IDLE at M+DRAIN_CYC+1.
  - A waiting requester is granted at M+DRAIN_CYC+2.
- A rel_x in the first granted cycle is legal: a zero-length transaction that goes straight to DRAIN.
- Read data from a rd strobe on the owner's final cycle arrives during DRAIN and is routed to that owner.
- Back-to-back transactions by the same requester are separated by DRAIN_CYC+1 idle cycles.
- Memory-output muxing is combinational from the state register. There is no extra pipeline stage between a requester and the memory.

## Test plan
1. Reset, then req_d alone at cycle 2, then rel_d at cycle 10 → gnt_d high cycles 3–10, busy high cycles 3–12, IDLE at cycle 13.
2. req_i and req_d both rise at cycle 2 after reset → gnt_d first. After rel_d, the still-pending req_i is granted at rel+4. A subsequent tie grants I.
3. Owner D issues rd_d with Addr_d = 16'h1230 on its release cycle, and memory returns 16'hBEEF 2 cycles later → DataOut_d = 16'hBEEF in DRAIN, DataOut_i = 16'h0000.
4. While D owns, I asserts wr_i with Addr_i = 16'h0040 → wr_mem follows wr_d only, memory never sees 16'h0040, err = 1 and stays 1 until rst.
5. rst asserted mid-OWN_I with rd_i = 1 → next cycle gnt_i = 0, rd_mem = 0, Addr_mem = 0, state IDLE. A tie after that grants D.
6. rel_i pulsed while D owns → ignored: gnt_d stays high and err = 1. rel_d then ends the transaction normally.
